spike_aer_encoder: RTL
======================

# spike_aer_encoder

- Sits directly downstream of the leaky integrate-and-fire neuron array.
- Turns its per-cycle 3-bit spike vector into a serial stream of 8-bit address-event words, in the layout {drop, timestamp, address}.
- Buffers events in a small FIFO so simultaneous spikes and output back-pressure do not lose events.
- Counts and flags events that are lost.
- Output drives the tile's dedicated output pins or a downstream consumer through a valid/ready handshake.

## Interface

Parameters:
- NUM_NEURONS, 3, width of spike_in; must be ≤ 4 because the address field is 2 bits.
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥ 2.
- TS_WIDTH, 5, timestamp field width; fixed so the event word is 8 bits.

Ports:
- clk, input, 1, single clock; all state on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, when low: no spike capture and the timestamp counter holds.
- spike_in, input, NUM_NEURONS, spike pulses from the neuron array; bit i is neuron i.
- out_data, output, 8, event word: bit7 = drop, bits6:2 = timestamp, bits1:0 = neuron address.
- out_valid, output, 1, out_data holds a valid event.
- out_ready, input, 1, consumer accepts the event.
- drop_count, output, 8, saturating count of lost spikes.
- fifo_full, output, 1, FIFO occupancy equals FIFO_DEPTH.

## Operation

Spike capture:
- pending[NUM_NEURONS-1:0] holds at most one outstanding spike per neuron.
- candidate = pending | (spike_in & {NUM_NEURONS{enable}}).

Push:
- Each edge, if the FIFO is not full and candidate ≠ 0, the lowest-index set bit of candidate is pushed.
- That bit is cleared: pending <= candidate & ~onehot(pushed).
- Otherwise pending <= candidate.
- Push is blocked whenever the FIFO is full, even if a pop occurs in the same cycle.

Drop:
- A spike_in[i] arriving (with enable high) while pending[i] is already 1 is lost.
- Each lost spike increments drop_count by 1; several lost spikes in one cycle add their total.
- drop_count saturates at 255.
- A sticky drop_flag is set on any loss.
- drop_flag is written into bit7 of the next pushed word and then cleared.
- If a loss and a push occur in the same cycle, the pushed word carries drop = 1 and drop_flag ends up 0.

Timestamp:
- ts_cnt is a TS_WIDTH-bit free-running counter.
- It increments each edge while enable is high and wraps 31 → 0.
- A word's timestamp is the ts_cnt value before the edge on which the word is pushed.

Output:
- out_data and out_valid come from the FIFO head (show-ahead).
- A transfer occurs when out_valid && out_ready on an edge.
- While out_valid && !out_ready, out_data stays stable.
- out_valid never drops without a transfer.
- Pop and push in the same cycle are both legal when the FIFO is not full.

Reset (asynchronous):
- pending, ts_cnt, drop_flag, drop_count and FIFO pointers/occupancy are all cleared to 0.
- Outputs in reset: out_valid = 0, out_data = 8'h00, fifo_full = 0, drop_count = 0.
- Reset in mid-operation discards all queued and pending events.

## Timing

- Latency: a spike on spike_in before edge k, with the FIFO empty and no older pending bits, gives out_valid = 1 after edge k.
- Throughput: one push per cycle and one pop per cycle.
- Simultaneous spikes: N spikes in the same cycle are serialized over N consecutive pushes, lowest address first.
- A neuron that fires while its own event is still pending loses the second spike.
- FIFO full: pushes stall and pending absorbs at most one spike per neuron; drops start only on a repeat spike from an already-pending neuron.
- enable low: spike_in is ignored, but the FIFO still drains and existing pending bits are still pushed.

## Configuration

SPIKE_AER_TIMESTAMP_EN:
- Defined: ts_cnt exists and bits6:2 carry the timestamp.
- Undefined: ts_cnt is not built and bits6:2 are always 0.
- Address, drop flag and handshake behaviour are identical in both cases.

## Structure

Package spike_aer_pkg:
- Event word bit positions: ADDR_LSB = 0, TS_LSB = 2, DROP_BIT = 7.
- EVENT_W = 8.
- Typedef for the event word.
- Lowest-set-bit priority function.

Sub-module spike_event_fifo:
- Synchronous show-ahead FIFO, EVENT_W bits wide by FIFO_DEPTH entries.
- Occupancy counter with full and empty flags.
- Same clk/rst_n as the top.

The top block contains the capture/arbitration logic, drop accounting and timestamp counter.

## Test plan

- Single spike: after reset, enable = 1, spike_in = 3'b010 for one cycle at ts 0, out_ready = 1. Expect one word 8'b0_00000_01, out_valid high for exactly 1 cycle, 1 cycle after the spike.
- Simultaneous spikes: spike_in = 3'b111 for one cycle at ts 4, out_ready = 1. Expect words with addresses 0, 1, 2 and timestamps 4, 5, 6 on consecutive cycles; drop_count = 0.
- Back-pressure and overflow: out_ready = 0, spike_in = 3'b001 every cycle for 12 cycles. Expect:
  - fifo_full after 8 pushes;
  - drop_count = 3;
  - with out_ready then raised, 9 words drained; the 9th word has bit7 = 1 and all earlier words have bit7 = 0.
- Stall stability: hold out_ready = 0 with out_valid = 1 for 5 cycles while new spikes arrive. Expect out_data unchanged until the transfer.
- Reset mid-stream: assert rst_n = 0 with 5 words queued. Expect out_valid = 0, drop_count = 0 and out_data = 0 immediately (asynchronously); after release, no stale words appear.
- Timestamp wrap and enable:
  - with SPIKE_AER_TIMESTAMP_EN defined, a spike after 33 enabled cycles gives timestamp 1;
  - enable = 0 for 10 cycles holds ts_cnt and ignores spike_in;
  - without SPIKE_AER_TIMESTAMP_EN, bits6:2 are always 0.

Source files
------------

// File: rtl/spike_aer_pkg.sv
// Shared definitions for the spike address-event encoder.
//   EVENT_W            : event word width (8 bits)
//   ADDR_LSB/TS_LSB/DROP_BIT : field positions inside the event word
//   event_word_t       : packed {drop, timestamp, address} layout
//   lowest_set_idx()   : priority encoder; index of the lowest set bit
package spike_aer_pkg;

    localparam int EVENT_W  = 8;
    localparam int ADDR_LSB = 0;
    localparam int TS_LSB   = 2;
    localparam int DROP_BIT = 7;
    localparam int ADDR_W   = TS_LSB - ADDR_LSB;
    localparam int TS_W     = DROP_BIT - TS_LSB;

    typedef struct packed {
        logic              drop;
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
    } event_word_t;

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic logic [ADDR_W-1:0] lowest_set_idx(input logic [3:0] v);
        logic [ADDR_W-1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready event stream from the encoder to its consumer.
//   out_data  : event word {drop, timestamp, address}
//   out_valid : out_data holds a valid event
//   out_ready : consumer accepts the event
// master = encoder side, slave = consumer side.
interface spike_aer_encoder_if;
    import spike_aer_pkg::*;

    logic [EVENT_W-1:0] out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/spike_event_fifo.sv
// Synchronous show-ahead FIFO for event words.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request (ignored while full)
//   pop               : remove head (ignored while empty)
//   head_data         : current head word, zero while empty
//   empty, full       : occupancy flags
module spike_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en_s;
    logic          pop_en_s;

    // Flags, head presentation and pointer/occupancy next state.
    always_comb begin
        empty     = (count_q == {CW{1'b0}});
        full      = (count_q == DEPTH_C);
        push_en_s = push && !full;
        pop_en_s  = pop && !empty;
        // Zero head while empty keeps out_data at 0 in and right after reset.
        if (empty) begin
            head_data = {W{1'b0}};
        end else begin
            head_data = mem[rd_ptr_q];
        end
        if (push_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_en_s, pop_en_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-vector to address-event-representation encoder.
//   clk, rst_n  : clock, asynchronous active-low reset
//   enable      : low = spike_in ignored and timestamp held
//   spike_in    : per-neuron spike pulses (bit i = neuron i)
//   aer         : out_data/out_valid/out_ready event stream (master)
//   drop_count  : saturating count of lost spikes
//   fifo_full   : event FIFO completely occupied
// Build option: SPIKE_AER_TIMESTAMP_EN adds the timestamp counter; without
// it the timestamp field of every word is 0.
module spike_aer_encoder
    import spike_aer_pkg::*;
#(
    parameter int NUM_NEURONS = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_NEURONS-1:0] spike_in,
    spike_aer_encoder_if.master    aer,
    output logic [7:0]             drop_count,
    output logic                   fifo_full
);

    logic [NUM_NEURONS-1:0] pending_q, pending_d;
    logic [NUM_NEURONS-1:0] spike_s, cand_s, lost_s;
    logic [3:0]             cand_ext_s;
    logic [3:0]             lost_cnt_s;
    logic [8:0]             drop_sum_s;
    logic [7:0]             drop_count_q, drop_count_d;
    logic                   drop_flag_q, drop_flag_d;
    logic                   push_s, pop_s, empty_s, full_s;
    logic [ADDR_W-1:0]      push_idx_s;
    logic [TS_WIDTH-1:0]    ts_s;
    event_word_t            word_s;
    logic [EVENT_W-1:0]     head_s;

`ifdef SPIKE_AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt_q, ts_cnt_d;

    // Free-running timestamp, frozen while disabled; wraps naturally.
    always_comb begin
        if (enable) begin
            ts_cnt_d = ts_cnt_q + TS_WIDTH'(1);
        end else begin
            ts_cnt_d = ts_cnt_q;
        end
        ts_s = ts_cnt_q;
    end

    // Timestamp register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q <= {TS_WIDTH{1'b0}};
        end else begin
            ts_cnt_q <= ts_cnt_d;
        end
    end
`else
    assign ts_s = {TS_WIDTH{1'b0}};
`endif

    // Capture, arbitration and drop accounting.
    always_comb begin
        spike_s = spike_in & {NUM_NEURONS{enable}};
        cand_s  = pending_q | spike_s;
        // A repeat spike on a neuron whose event is still waiting is lost.
        lost_s  = pending_q & spike_s;

        cand_ext_s = 4'b0000;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cand_ext_s[i] = cand_s[i];
        end
        push_idx_s = lowest_set_idx(cand_ext_s);
        // Full blocks the push even when a pop frees a slot this cycle.
        push_s     = !full_s && (cand_s != {NUM_NEURONS{1'b0}});

        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (push_s && (i == int'(push_idx_s))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = cand_s[i];
            end
        end

        lost_cnt_s = 4'd0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (lost_s[i]) begin
                lost_cnt_s = lost_cnt_s + 4'd1;
            end else begin
                lost_cnt_s = lost_cnt_s;
            end
        end
        drop_sum_s = {1'b0, drop_count_q} + {5'b00000, lost_cnt_s};
        if (drop_sum_s[8]) begin
            drop_count_d = 8'hFF;
        end else begin
            drop_count_d = drop_sum_s[7:0];
        end

        // A loss in the same cycle as a push is reported by that word.
        word_s.drop = drop_flag_q | (lost_s != {NUM_NEURONS{1'b0}});
        word_s.ts   = ts_s;
        word_s.addr = push_idx_s;
        if (push_s) begin
            drop_flag_d = 1'b0;
        end else begin
            drop_flag_d = word_s.drop;
        end

        pop_s = !empty_s && aer.out_ready;
    end

    // Pending spikes, drop flag and drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= {NUM_NEURONS{1'b0}};
            drop_flag_q  <= 1'b0;
            drop_count_q <= 8'h00;
        end else begin
            pending_q    <= pending_d;
            drop_flag_q  <= drop_flag_d;
            drop_count_q <= drop_count_d;
        end
    end

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVENT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (word_s),
        .pop       (pop_s),
        .head_data (head_s),
        .empty     (empty_s),
        .full      (full_s)
    );

    assign aer.out_data  = head_s;
    assign aer.out_valid = !empty_s;
    assign drop_count    = drop_count_q;
    assign fifo_full     = full_s;

endmodule
